// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detected capture into a first-word-fall-through FIFO.
// Latency: a word captured at edge E is visible on Rd_Valid/Rd_Data/Fifo_Count right after E.
// Backpressure: Rx_Start drops while full; words arriving while full (and not popped) set Overflow.
module uart_rx_fifo #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       Clk_Rx,
  input  logic                       Rst,
  input  logic [WORD_SIZE-1:0]       Rx_Data,
  input  logic                       Rx_Done,
  input  logic                       Rx_Error,
  output logic                       Rx_Start,
  output logic [WORD_SIZE-1:0]       Rd_Data,
  output logic                       Rd_Valid,
  input  logic                       Rd_Ready,
  output logic [$clog2(DEPTH):0]     Fifo_Count,
  output logic                       Overflow,
  output logic [7:0]                 Frame_Err_Cnt,
  input  logic                       Clr_Status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_next;
  logic                 done_q;
  logic                 err_q;
  logic                 push;
  logic                 err_evt;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 wr_en;
  logic                 ovf_evt;

  // Rising-edge detection; both history bits reset high so a level already
  // asserted when reset releases is not mistaken for a new event.
  assign push    = Rx_Done & ~done_q;
  assign err_evt = Rx_Error & ~err_q;

  assign full  = (Fifo_Count == CW'(DEPTH));
  assign empty = (Fifo_Count == '0);

  assign Rd_Valid = ~empty;
  assign Rd_Data  = Rd_Valid ? mem[rd_ptr] : '0;
  assign pop      = Rd_Valid & Rd_Ready;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
  assign wr_en   = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;

  // Next occupancy; simultaneous write and pop leave it unchanged.
  always_comb begin
    count_next = Fifo_Count;
    if (wr_en && !pop) begin
      count_next = Fifo_Count + CW'(1);
    end else if (!wr_en && pop) begin
      count_next = Fifo_Count - CW'(1);
    end
  end

  // Edge-detect history registers.
  always_ff @(posedge Clk_Rx or posedge Rst) begin
    if (Rst) begin
      done_q <= 1'b1;
      err_q  <= 1'b1;
    end else begin
      done_q <= Rx_Done;
      err_q  <= Rx_Error;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge Clk_Rx) begin
    if (wr_en) begin
      mem[wr_ptr] <= Rx_Data;
    end
  end

  // Pointers, occupancy and receive enable; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk_Rx or posedge Rst) begin
    if (Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Fifo_Count <= '0;
      Rx_Start   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      Fifo_Count <= count_next;
      Rx_Start   <= (count_next != CW'(DEPTH));
    end
  end

  // Sticky status: a new event in the same cycle as a clear takes priority.
  always_ff @(posedge Clk_Rx or posedge Rst) begin
    if (Rst) begin
      Overflow      <= 1'b0;
      Frame_Err_Cnt <= 8'd0;
    end else begin
      if (ovf_evt) begin
        Overflow <= 1'b1;
      end else if (Clr_Status) begin
        Overflow <= 1'b0;
      end
      if (err_evt) begin
        if (Clr_Status) begin
          Frame_Err_Cnt <= 8'd1;
        end else if (Frame_Err_Cnt != 8'hFF) begin
          Frame_Err_Cnt <= Frame_Err_Cnt + 8'd1;
        end
      end else if (Clr_Status) begin
        Frame_Err_Cnt <= 8'd0;
      end
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer that sits directly downstream of the UART receiver. It captures each completed word from the receiver's done/data/error outputs into a DEPTH-entry first-word-fall-through FIFO and presents the words on a valid/ready read port. It throttles the receiver through Rx_Start when the buffer is full, and keeps a sticky overflow flag and a saturating framing-error counter.

## Interface
- WORD_SIZE, 8: data word width; must match the receiver's WORD_SIZE.
- DEPTH, 16: FIFO entries; power of two, at least 2.

- Clk_Rx  in  1  receiver oversample clock, shared with the receiver.
- Rst  in  1  asynchronous, active-high reset.
- Rx_Data  in  WORD_SIZE  receiver data; valid when Rx_Done rises.
- Rx_Done  in  1  receiver word-complete strobe.
- Rx_Error  in  1  receiver start/parity/stop error strobe.
- Rx_Start  out  1  receive enable to the receiver.
- Rd_Data  out  WORD_SIZE  head-of-FIFO word; 0 when Rd_Valid is low.
- Rd_Valid  out  1  FIFO not empty.
- Rd_Ready  in  1  consumer accepts Rd_Data.
- Fifo_Count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- Overflow  out  1  sticky; a word arrived while the FIFO was full.
- Frame_Err_Cnt  out  8  saturating count of Rx_Error events.
- Clr_Status  in  1  synchronous clear of Overflow and Frame_Err_Cnt.

## Operation
- **Edge detect:**
  - Registers done_q and err_q sample Rx_Done and Rx_Error each cycle.
  - Both registers reset to 1, so a level that is already high out of reset is never captured.
  - push = Rx_Done & ~done_q.
  - err_evt = Rx_Error & ~err_q.
  - A level held high for N cycles counts as exactly one event.
- **Storage:**
  - Register array of DEPTH words, with wr_ptr and rd_ptr each $clog2(DEPTH) bits; both pointers wrap modulo DEPTH.
  - Fifo_Count is a separate register.
  - full = (Fifo_Count == DEPTH); empty = (Fifo_Count == 0).
- **Pop:**
  - pop = Rd_Valid & Rd_Ready.
  - rd_ptr advances; count decrements.
  - Rd_Ready while empty has no effect.
- **Push:**
  - If not full: mem[wr_ptr] <= Rx_Data, wr_ptr advances, count increments.
  - If full and pop is low: the word is dropped, Overflow is set, and pointers and count are unchanged.
- **Push and pop in the same cycle:**
  - Both pointers advance and the count is unchanged.
  - This includes the full case: a pop in the same cycle frees the slot, so the push is accepted and Overflow is not set.
  - From empty, the pop cannot occur because Rd_Valid is low; the push proceeds.
- **Read port:**
  - Rd_Valid = ~empty.
  - Rd_Data = mem[rd_ptr] when Rd_Valid is high, else 0.
  - Both are combinational from registers only.
- **Rx_Start:**
  - Registered, loaded each cycle with (count_next != DEPTH).
  - After the first post-reset edge, Rx_Start == ~full.
  - The receiver finishes any frame already in progress, so an Overflow indicates an external protocol violation or a pre-armed receiver.
- **Errors:**
  - err_evt increments Frame_Err_Cnt, saturating at 255.
  - No FIFO write occurs on an error; Rx_Data is ignored.
- **Clr_Status:**
  - Clears Overflow and Frame_Err_Cnt.
  - If a new overflow or err_evt occurs in the same cycle, the event wins: Overflow = 1, Frame_Err_Cnt = 1.
- **Reset (asynchronous, any time, including mid-frame):**
  - Pointers 0, Fifo_Count 0, Rd_Valid 0, Rd_Data 0, Rx_Start 0.
  - Overflow 0, Frame_Err_Cnt 0, done_q 1, err_q 1.
  - Memory contents are not reset.
  - Rx_Start returns to 1 on the first edge after Rst deasserts.

## Timing
- push sampled at edge E → Rd_Valid and Fifo_Count updated after E (1-cycle latency).
- Rd_Data reflects the new head in the cycle after a pop edge, with no bubble.
- Rx_Start falls after the edge that makes the FIFO full, and rises after the edge that pops from full.
- Overflow and Frame_Err_Cnt update at the edge where the event is sampled.
- No combinational path from Rd_Ready to Rd_Valid or Rd_Data.

## Test plan
- **Single word:** reset, then Rx_Data=0xA5 with Rx_Done pulsed 1 cycle → next cycle Rd_Valid=1, Rd_Data=0xA5, Fifo_Count=1; pop with Rd_Ready → Rd_Valid=0, Rd_Data=0, Fifo_Count=0.
- **Fill and wrap:** push 16 words 0x00..0x0F with Rd_Ready=0 → Fifo_Count=16, Rx_Start=0; pop all → order 0x00..0x0F; push/pop 20 more → pointer wrap preserves order.
- **Overflow:** push 0x11 while full and not popping → Overflow=1, Fifo_Count stays 16, 0x11 never read; repeat with a simultaneous pop → accepted, Overflow unchanged.
- **Held levels:** Rx_Done held high 5 cycles → exactly one word stored; Rx_Error held high 3 cycles → Frame_Err_Cnt=1; 300 error pulses → 255.
- **Clear:** Clr_Status with err_evt in the same cycle → Frame_Err_Cnt=1, Overflow=0.
- **Reset mid-stream:** assert Rst with 5 words stored → all outputs at reset values immediately (asynchronously); Rx_Done high at deassertion → no word captured; Rx_Start=1 one edge after release.
